// File: rtl/poly_mult_host_seq.sv
// poly_mult_host_seq: streams operand words into a multiplier target, starts it and collects its result
// Ports: clk/rst clock and sync reset; go_i job request; src_valid_i/src_data_i/src_ready_o operand stream;
//        load_o/key_o/data_o target command; busy_i/data_i target status and result;
//        res_valid_o/res_data_o result pulse and held value; busy_o job active; err_o sticky timeout flag
module poly_mult_host_seq #(
  parameter int WEIGHT     = 66,
  parameter int RAND_WORDS = 553,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go_i,
  input  logic         src_valid_i,
  input  logic [31:0]  src_data_i,
  output logic         src_ready_o,
  output logic         load_o,
  output logic [9:0]   key_o,
  output logic [127:0] data_o,
  input  logic         busy_i,
  input  logic [127:0] data_i,
  output logic         res_valid_o,
  output logic [127:0] res_data_o,
  output logic         busy_o,
  output logic         err_o
);
  localparam int N  = WEIGHT + RAND_WORDS;
  localparam int IW = $clog2(N + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, GUARD, WAIT} state_t;
  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic          hs;
  logic [31:0]   word_d;
  always_comb begin
    hs     = src_valid_i & src_ready_o;
    word_d = idx_q < IW'(WEIGHT) ? {16'h0, src_data_i[15:0]} : src_data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      src_ready_o <= 1'b0;
      load_o      <= 1'b0;
      key_o       <= '0;
      data_o      <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      res_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          load_o <= 1'b0;
          key_o  <= '0;
          data_o <= '0;
          if (go_i) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b1;
            src_ready_o <= 1'b1;
          end
        end
        LOAD: begin
          // idle pattern by default; overridden by a nonzero handshaken word
          load_o <= 1'b1;
          key_o  <= 10'h3FF;
          data_o <= '0;
          if (hs) begin
            idx_q <= idx_q + 1'b1;
            if (word_d != '0) begin
              key_o  <= 10'(idx_q);
              data_o <= {96'h0, word_d};
            end
            if (idx_q == IW'(N - 1)) begin
              src_ready_o <= 1'b0;
              state_q     <= START;
            end
          end
        end
        START: begin
          load_o  <= 1'b1;
          key_o   <= 10'h3FF;
          data_o  <= '1;
          state_q <= GUARD;
        end
        GUARD: begin
          // one settling cycle: busy_i is not yet meaningful here
          load_o  <= 1'b0;
          key_o   <= '0;
          data_o  <= '0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!busy_i) begin
            res_data_o  <= data_i;
            res_valid_o <= 1'b1;
            busy_o      <= 1'b0;
            state_q     <= IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_mult_host_seq.sv
// tb_poly_mult_host_seq: scoreboard bench for the operand-loading host sequencer
module tb_poly_mult_host_seq;
  localparam int W = 66;
  localparam int R = 553;
  localparam int N = W + R;
  logic clk = 0, rst = 1;
  logic go = 0, sv = 0, busy = 0, srdy, ld, rv, bo, er;
  logic [31:0] sd = '0;
  logic [9:0] key;
  logic [127:0] dat, td = '0, rd;
  logic go2 = 0, sv2 = 0, busy2 = 0, srdy2, ld2, rv2, bo2, er2;
  logic [31:0] sd2 = '0;
  logic [9:0] key2;
  logic [127:0] dat2, td2 = '0, rd2;
  int total = 0, passed = 0;
  typedef struct { int z0; int z1; bit tog; int bsy; } job_t;
  job_t tbl [4];
  always #5 clk = ~clk;
  poly_mult_host_seq dut (
    .clk(clk), .rst(rst), .go_i(go), .src_valid_i(sv), .src_data_i(sd), .src_ready_o(srdy),
    .load_o(ld), .key_o(key), .data_o(dat), .busy_i(busy), .data_i(td),
    .res_valid_o(rv), .res_data_o(rd), .busy_o(bo), .err_o(er)
  );
  poly_mult_host_seq #(.WEIGHT(2), .RAND_WORDS(3), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst), .go_i(go2), .src_valid_i(sv2), .src_data_i(sd2), .src_ready_o(srdy2),
    .load_o(ld2), .key_o(key2), .data_o(dat2), .busy_i(busy2), .data_i(td2),
    .res_valid_o(rv2), .res_data_o(rd2), .busy_o(bo2), .err_o(er2)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [31:0] msk(input int i, input logic [31:0] w);
    return i < W ? {16'h0, w[15:0]} : w;
  endfunction
  task automatic run_job(input job_t j);
    logic [31:0] words [N];
    logic [31:0] t;
    logic [127:0] tres;
    int ptr = 0, widx = 0, cyc = 0, start_at = -1, res_at = -1, zero_at = -1, idles = 0, stalls = 0;
    int writes = 0, starts = 0, results = 0, brem = 0, zeros = 0;
    bit done = 0, v;
    for (int i = 0; i < N; i++) begin
      t = $urandom;
      if (i == j.z0 || i == j.z1) words[i] = i < W ? {t[15:0] | 16'h1, 16'h0} : 32'h0;
      else begin
        if (t[15:0] == 16'h0) t[0] = 1'b1;
        words[i] = t;
      end
      if (msk(i, words[i]) == 32'h0) zeros++;
    end
    tres = {$urandom, $urandom, $urandom, $urandom};
    td = tres;
    busy = 0;
    go = 1;
    @(negedge clk);
    go = 0;
    chk("go_busy", bo, 1);
    chk("go_err", er, 0);
    while (!done && cyc < 5000) begin
      if (ld && key != 10'h3FF) begin
        writes++;
        while (widx < N && msk(widx, words[widx]) == 32'h0) widx++;
        chk("wr_key", key, widx);
        chk("wr_data", dat, widx < N ? {96'h0, msk(widx, words[widx])} : 128'h0);
        widx++;
      end else if (ld && key == 10'h3FF && dat == 128'h0) idles++;
      else if (ld && key == 10'h3FF && &dat) begin
        starts++;
        start_at = cyc;
      end
      if (!ld && start_at >= 0 && zero_at < 0) zero_at = cyc;
      if (rv) begin
        results++;
        res_at = cyc;
        chk("res_data", rd, tres);
      end
      if (!bo) done = 1;
      if (start_at == cyc) begin
        busy = j.bsy > 0;
        brem = j.bsy;
      end else if (start_at >= 0) begin
        busy = brem > 0;
        if (brem > 0) brem--;
      end
      v = j.tog ? (cyc % 2 == 0) : 1'b1;
      sv = v && ptr < N;
      sd = ptr < N ? words[ptr] : $urandom;
      if (ptr < N && !v) stalls++;
      if (ptr < N && v) ptr++;
      go = cyc == 40;
      cyc++;
      @(negedge clk);
    end
    sv = 0;
    go = 0;
    chk("job_done", done, 1);
    chk("write_count", writes, N - zeros);
    chk("idle_count", idles, stalls + zeros);
    chk("start_count", starts, 1);
    chk("guard_zero", zero_at - start_at, 1);
    chk("result_count", results, 1);
    chk("result_latency", res_at - start_at, j.bsy + 2);
    chk("end_err", er, 0);
    chk("end_ready", srdy, 0);
    chk("pulse_drop", rv, 0);
    chk("res_hold", rd, tres);
  endtask
  task automatic small_job(input int hold);
    int cyc = 0, start_at = -1, end_at = -1, brem = hold, results = 0;
    logic [127:0] tres;
    bit done = 0;
    tres = {$urandom, $urandom, $urandom, $urandom};
    td2 = tres;
    busy2 = 0;
    go2 = 1;
    @(negedge clk);
    go2 = 0;
    chk("s_go_err", er2, 0);
    chk("s_go_busy", bo2, 1);
    while (!done && cyc < 300) begin
      if (ld2 && key2 == 10'h3FF && &dat2) start_at = cyc;
      if (rv2) begin
        results++;
        chk("s_res_data", rd2, tres);
      end
      if (!bo2) begin
        done = 1;
        end_at = cyc;
      end
      if (start_at == cyc) busy2 = 1;
      else if (start_at >= 0) begin
        busy2 = brem > 0;
        if (brem > 0) brem--;
      end
      sv2 = 1;
      sd2 = $urandom | 32'h1;
      cyc++;
      @(negedge clk);
    end
    sv2 = 0;
    busy2 = 0;
    chk("s_done", done, 1);
    chk("s_latency", end_at - start_at, hold < 16 ? hold + 2 : 17);
    chk("s_results", results, hold < 16 ? 1 : 0);
    chk("s_err", er2, hold < 16 ? 0 : 1);
    chk("s_busy", bo2, 0);
  endtask
  initial begin
    tbl[0] = '{-1, -1, 1'b0, 200};
    tbl[1] = '{5, 100, 1'b0, 20};
    tbl[2] = '{-1, -1, 1'b1, 30};
    tbl[3] = '{65, 618, 1'b1, 0};
    repeat (3) @(negedge clk);
    chk("rst_outputs", {ld, key, dat, srdy, rv, rd, bo, er}, '0);
    chk("rst_outputs2", {ld2, key2, dat2, srdy2, rv2, rd2, bo2, er2}, '0);
    rst = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) run_job(tbl[k]);
    small_job(16);
    small_job(15);
    small_job(40);
    small_job(3);
    go = 1;
    @(negedge clk);
    go = 0;
    for (int i = 0; i < 300; i++) begin
      sv = 1;
      sd = $urandom | 32'h1;
      @(negedge clk);
    end
    chk("pre_rst_key", key, 299);
    sv = 0;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_outputs", {ld, key, dat, srdy, rv, rd, bo, er}, '0);
    rst = 0;
    @(negedge clk);
    run_job(tbl[1]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/poly_mult_host_seq.md
POLY_MULT_HOST_SEQ -- requirements
Module: poly_mult_host_seq

Interface
REQ-001 SHALL have parameter WEIGHT, default 66, number of shift-position words (keys 0..WEIGHT-1).
REQ-002 SHALL have parameter RAND_WORDS, default 553, number of random-vector words (keys WEIGHT..WEIGHT+RAND_WORDS-1).
REQ-003 SHALL have parameter TIMEOUT, default 1_000_000, maximum number of WAIT cycles before abort.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports go_i in 1 (job request pulse); src_valid_i in 1, src_data_i in 32, src_ready_o out 1 (operand stream: positions first, then random words).
REQ-006 SHALL have target-side ports load_o out 1, key_o out 10, data_o out 128 (command to target); busy_i in 1, data_i in 128 (target status and result).
REQ-007 SHALL have ports res_valid_o out 1 (result pulse), res_data_o out 128, busy_o out 1 (job in progress), err_o out 1 (sticky timeout flag).

Function
REQ-008 SHALL implement states IDLE, LOAD, START, GUARD, WAIT; all outputs SHALL be registered.
REQ-009 IDLE: go_i=1 -> LOAD next edge, index cleared to 0, err_o cleared, busy_o=1; go_i in any other state SHALL be ignored.
REQ-010 LOAD: src_ready_o=1 while index < WEIGHT+RAND_WORDS; handshake = src_valid_i & src_ready_o.
REQ-011 On handshake edge: load_o<=1, key_o<=index, index<=index+1; data_o<=zero-extended src_data_i[15:0] if index<WEIGHT, else zero-extended src_data_i[31:0].
REQ-012 A handshaken word equal to zero (after masking per REQ-011) SHALL NOT be written: drive the idle pattern instead, with index still incremented.
REQ-013 Idle pattern: load_o=1, key_o=10'h3FF, data_o=0; driven in LOAD on every cycle without handshake (stall).
REQ-014 Handshake of the last word (index = WEIGHT+RAND_WORDS-1) -> START on the next edge.
REQ-015 START: exactly one cycle with load_o=1, key_o=10'h3FF, data_o=all ones (start command), then -> GUARD.
REQ-016 GUARD: load_o=0, key_o=0, data_o=0 for exactly one cycle; busy_i SHALL be ignored; then -> WAIT.
REQ-017 WAIT: load_o=0; on the first edge with busy_i=0: res_data_o<=data_i, res_valid_o<=1 for one cycle, busy_o<=0, -> IDLE.
REQ-018 WAIT cycle counter SHALL start at 0 on entry; when it reaches TIMEOUT-1 with busy_i still 1: err_o<=1, busy_o<=0, no res_valid_o pulse, -> IDLE.
REQ-019 busy_i=0 on the same edge as the timeout SHALL count as success (REQ-017 wins).
REQ-020 res_data_o SHALL hold its value until the next successful capture; err_o SHALL stay set until the next accepted go_i.
REQ-021 src_ready_o SHALL be 0 in every state except LOAD; no source word is consumed outside LOAD.
REQ-022 Index width SHALL be wide enough for WEIGHT+RAND_WORDS; key_o SHALL never equal 10'h3FF for a data write (requires WEIGHT+RAND_WORDS <= 1023).

Reset
REQ-023 rst=1 at an edge SHALL force IDLE: load_o=0, key_o=0, data_o=0, src_ready_o=0, res_valid_o=0, res_data_o=0, busy_o=0, err_o=0, index and WAIT counter 0.
REQ-024 Reset mid-job (any state) SHALL abandon the job with no result pulse; load_o low from the first reset edge.

Verification
REQ-025 Full job, WEIGHT=66, RAND_WORDS=553, src always valid, nonzero words, target model busy for 200 cycles -> 619 consecutive write cycles keys 0..618, one all-ones command on key 3FF, res_valid_o one pulse with captured data_i.
REQ-026 Zero word at index 5 and index 100 -> idle pattern in those slots, keys 5 and 100 never carry writes, following keys continue at 6 and 101.
REQ-027 src_valid_i toggled every other cycle -> idle pattern on stall cycles, key sequence gap-free, total job completes.
REQ-028 TIMEOUT=16, busy_i held 1 -> err_o=1 after 16 WAIT cycles, no res_valid_o, busy_o=0; next go_i clears err_o.
REQ-029 rst asserted during LOAD at index 300 -> all outputs at reset values next edge; new go_i restarts at key 0.
REQ-030 busy_i already 0 during GUARD -> ignored; capture occurs in first WAIT cycle.
